// File: rtl/cache_arbiter_pkg.sv
// cache_defs: definitions shared by the cache arbiter slice.
//   line_size_default - default width of address / data buses
//   state_t           - arbiter FSM states
//   op_t              - latched operation type
//   decode_op()       - maps a requester's strobes to the op it asks for
package cache_defs;

    localparam int line_size_default = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // A request with both strobes set is a write, so only the write strobe
    // decides the op once a request is known to be pending.
    function automatic op_t decode_op(input logic write);
        if (write) begin
            return OP_WRITE;
        end else begin
            return OP_READ;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: one read/write cache-style bus.
//   read, write  - request strobes (master -> slave)
//   address      - request address (master -> slave)
//   writedata    - write data (master -> slave)
//   readdata     - read data (slave -> master)
//   busywait     - stall (slave -> master)
// The CPU-side ports of the arbiter are slaves; the cache-side port is a master.
interface cache_arbiter_if
    import cache_defs::*;
#(
    parameter int line_size = line_size_default
) ();

    logic                 read;
    logic                 write;
    logic [line_size-1:0] address;
    logic [line_size-1:0] writedata;
    logic [line_size-1:0] readdata;
    logic                 busywait;

    modport master (
        output read,
        output write,
        output address,
        output writedata,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata,
        output busywait
    );

endinterface

// File: rtl/cache_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   pending[1:0] - request pending per requester
//   last_grant   - requester that owned the previous transaction
//   grant        - index of the winning requester
//   grant_valid  - at least one request is pending
module rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant       = 1'b0;
        grant_valid = |pending;
        case (pending)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache between an instruction-fetch requester (r0)
// and a data requester (r1).
//   clk    - system clock, all state changes on posedge
//   reset  - synchronous, active-high
//   r0, r1 - CPU-side slave ports (read/write/address/writedata in,
//            readdata registered out, busywait combinational out)
//   cache  - master port towards the cache (strobes and latched
//            address/writedata registered out, readdata/busywait in)
// One request is latched at a time and replayed to the cache from the latches,
// so a requester changing its inputs mid-transaction cannot disturb the cache.
module cache_arbiter
    import cache_defs::*;
#(
    parameter int line_size = line_size_default
) (
    input  logic           clk,
    input  logic           reset,
    cache_arbiter_if.slave  r0,
    cache_arbiter_if.slave  r1,
    cache_arbiter_if.master cache
);

    state_t               state_r;
    logic                 owner_r;
    logic                 last_grant_r;
    op_t                  op_r;
    logic                 cache_read_r;
    logic                 cache_write_r;
    logic [line_size-1:0] address_r;
    logic [line_size-1:0] writedata_r;
    logic [line_size-1:0] r0_readdata_r;
    logic [line_size-1:0] r1_readdata_r;

    logic [1:0]           pending_s;
    logic                 grant_s;
    logic                 grant_valid_s;
    logic                 sel_write_s;
    logic [line_size-1:0] sel_address_s;
    logic [line_size-1:0] sel_writedata_s;
    op_t                  sel_op_s;

    assign pending_s = {r1.read | r1.write, r0.read | r0.write};

    rr_pick2 u_pick (
        .pending     (pending_s),
        .last_grant  (last_grant_r),
        .grant       (grant_s),
        .grant_valid (grant_valid_s)
    );

    // Route the granted requester's request towards the latches.
    always_comb begin
        sel_write_s     = 1'b0;
        sel_address_s   = {line_size{1'b0}};
        sel_writedata_s = {line_size{1'b0}};
        if (grant_s) begin
            sel_write_s     = r1.write;
            sel_address_s   = r1.address;
            sel_writedata_s = r1.writedata;
        end else begin
            sel_write_s     = r0.write;
            sel_address_s   = r0.address;
            sel_writedata_s = r0.writedata;
        end
    end

    assign sel_op_s = decode_op(sel_write_s);

    // Arbiter FSM with request latches and registered cache/readdata outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            op_r          <= OP_READ;
            cache_read_r  <= 1'b0;
            cache_write_r <= 1'b0;
            address_r     <= {line_size{1'b0}};
            writedata_r   <= {line_size{1'b0}};
            r0_readdata_r <= {line_size{1'b0}};
            r1_readdata_r <= {line_size{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r       <= grant_s;
                        last_grant_r  <= grant_s;
                        op_r          <= sel_op_s;
                        address_r     <= sel_address_s;
                        writedata_r   <= sel_writedata_s;
                        cache_read_r  <= (sel_op_s == OP_READ);
                        cache_write_r <= (sel_op_s == OP_WRITE);
                        state_r       <= ACTIVE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (!cache.busywait) begin
                        cache_read_r  <= 1'b0;
                        cache_write_r <= 1'b0;
                        state_r       <= RESP;
                        // Writes leave the owner's readdata untouched.
                        if (op_r == OP_READ) begin
                            if (owner_r) begin
                                r1_readdata_r <= cache.readdata;
                            end else begin
                                r0_readdata_r <= cache.readdata;
                            end
                        end
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    cache_read_r  <= 1'b0;
                    cache_write_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign cache.read      = cache_read_r;
    assign cache.write     = cache_write_r;
    assign cache.address   = address_r;
    assign cache.writedata = writedata_r;

    assign r0.readdata = r0_readdata_r;
    assign r1.readdata = r1_readdata_r;

    // Only the owner is released, and only during its single RESP cycle.
    assign r0.busywait = pending_s[0] & ~((state_r == RESP) & (owner_r == 1'b0));
    assign r1.busywait = pending_s[1] & ~((state_r == RESP) & (owner_r == 1'b1));

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected cache
// transactions and requester completions; monitors pop and compare.
module tb_cache_arbiter;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
        int          start;
    } cache_exp_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          done;
    } resp_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_cfg = 0;
    int   cnt = 0;

    cache_exp_t cache_q[$];
    resp_exp_t  resp_q[$];

    cache_arbiter_if r0_bus ();
    cache_arbiter_if r1_bus ();
    cache_arbiter_if cache_bus ();

    cache_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .r0    (r0_bus),
        .r1    (r1_bus),
        .cache (cache_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: stalls busy_cfg cycles per transaction, data = address ^ const.
    always @(posedge clk) begin
        if (cache_bus.read | cache_bus.write) cnt <= cnt + 1;
        else cnt <= 0;
    end
    assign cache_bus.busywait = (cache_bus.read | cache_bus.write) && (cnt < busy_cfg);
    assign cache_bus.readdata = cache_bus.address ^ 32'hDEADBEEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_resp(input int i, input logic [31:0] data);
        resp_exp_t e;
        if (resp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: r%0d released at cycle %0d, expected no completion", i, cyc);
        end else begin
            e = resp_q.pop_front();
            chk("done_owner", i, e.owner);
            chk("done_readdata", data, e.data);
            chk("done_cycle", cyc, e.done);
        end
    endtask

    // Requester monitor: a completion is a pending strobe with busywait low.
    initial begin
        forever begin
            @(negedge clk);
            if ((r0_bus.read | r0_bus.write) && !r0_bus.busywait) check_resp(0, r0_bus.readdata);
            if ((r1_bus.read | r1_bus.write) && !r1_bus.busywait) check_resp(1, r1_bus.readdata);
        end
    end

    // Cache monitor: checks each strobe burst's op, address, data, start and length.
    initial begin
        cache_exp_t cur;
        bit prev = 1'b0;
        bit s;
        bit have = 1'b0;
        int len = 0;
        forever begin
            @(negedge clk);
            s = cache_bus.read | cache_bus.write;
            if (s && !prev) begin
                len = 1;
                if (cache_q.size() == 0) begin
                    have = 1'b0;
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cache_txn: addr %h at cycle %0d, expected none", cache_bus.address, cyc);
                end else begin
                    have = 1'b1;
                    cur = cache_q.pop_front();
                    chk("cache_strobes", {30'd0, cache_bus.read, cache_bus.write}, cur.op ? 32'd1 : 32'd2);
                    chk("cache_address", cache_bus.address, cur.addr);
                    chk("cache_writedata", cache_bus.writedata, cur.wdata);
                    chk("cache_start", cyc, cur.start);
                end
            end else if (s) begin
                len++;
                if (have) begin
                    chk("cache_address_hold", cache_bus.address, cur.addr);
                    chk("cache_writedata_hold", cache_bus.writedata, cur.wdata);
                end
            end else if (prev && have) begin
                chk("cache_strobe_len", len, cur.len);
            end
            prev = s;
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (i == 0) begin
            r0_bus.read = rd; r0_bus.write = wr; r0_bus.address = addr; r0_bus.writedata = wd;
        end else begin
            r1_bus.read = rd; r1_bus.write = wr; r1_bus.address = addr; r1_bus.writedata = wd;
        end
    endtask

    // Waits (bounded) for requester i's release, then returns just after the next posedge.
    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (i == 0) seen = (r0_bus.read | r0_bus.write) && !r0_bus.busywait;
            else        seen = (r1_bus.read | r1_bus.write) && !r1_bus.busywait;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: r%0d busywait still high after 50 cycles, expected release", i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_cache_read", {31'd0, cache_bus.read}, 32'd0);
        chk("rst_cache_write", {31'd0, cache_bus.write}, 32'd0);
        chk("rst_cache_address", cache_bus.address, 32'd0);
        chk("rst_cache_writedata", cache_bus.writedata, 32'd0);
        chk("rst_r0_readdata", r0_bus.readdata, 32'd0);
        chk("rst_r1_readdata", r1_bus.readdata, 32'd0);
        chk("rst_r0_busywait", {31'd0, r0_bus.busywait}, 32'd0);
        chk("rst_r1_busywait", {31'd0, r1_bus.busywait}, 32'd0);

        // r0 read of address 1, no cache stall
        wait_cycle();
        busy_cfg = 0;
        c = cyc;
        cache_q.push_back('{1'b0, 32'd1, 32'd0, 1, c + 1});
        resp_q.push_back('{0, 32'hDEADBEEF, c + 2});
        drive(0, 1'b1, 1'b0, 32'd1, 32'd0);
        wait_done(0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("r1_readdata_untouched", r1_bus.readdata, 32'd0);

        // r1 write, cache stalls 3 cycles
        busy_cfg = 3;
        c = cyc;
        cache_q.push_back('{1'b1, 32'd2, 32'h12345678, 4, c + 1});
        resp_q.push_back('{1, 32'd0, c + 5});
        drive(1, 1'b0, 1'b1, 32'd2, 32'h12345678);
        wait_done(1);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Simultaneous requests after reset: r0 first
        do_reset();
        busy_cfg = 0;
        c = cyc;
        cache_q.push_back('{1'b0, 32'd3, 32'd0, 1, c + 1});
        cache_q.push_back('{1'b0, 32'd4, 32'd0, 1, c + 4});
        resp_q.push_back('{0, 32'hDEADBEED, c + 2});
        resp_q.push_back('{1, 32'hDEADBEEA, c + 5});
        drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd4, 32'd0);
        fork
            begin wait_done(0); drive(0, 1'b0, 1'b0, 32'd0, 32'd0); end
            begin wait_done(1); drive(1, 1'b0, 1'b0, 32'd0, 32'd0); end
        join

        // Continuous re-requests: owners alternate 0,1,0,1
        c = cyc;
        cache_q.push_back('{1'b0, 32'h10, 32'd0, 1, c + 1});
        cache_q.push_back('{1'b0, 32'h20, 32'd0, 1, c + 4});
        cache_q.push_back('{1'b0, 32'h11, 32'd0, 1, c + 7});
        cache_q.push_back('{1'b0, 32'h21, 32'd0, 1, c + 10});
        resp_q.push_back('{0, 32'hDEADBEFE, c + 2});
        resp_q.push_back('{1, 32'hDEADBECE, c + 5});
        resp_q.push_back('{0, 32'hDEADBEFF, c + 8});
        resp_q.push_back('{1, 32'hDEADBECF, c + 11});
        fork
            begin
                drive(0, 1'b1, 1'b0, 32'h10, 32'd0); wait_done(0);
                drive(0, 1'b1, 1'b0, 32'h11, 32'd0); wait_done(0);
                drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            begin
                drive(1, 1'b1, 1'b0, 32'h20, 32'd0); wait_done(1);
                drive(1, 1'b1, 1'b0, 32'h21, 32'd0); wait_done(1);
                drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        join

        // Read and write together is a write; r0 readdata keeps its last read
        c = cyc;
        cache_q.push_back('{1'b1, 32'd5, 32'hA5A5A5A5, 1, c + 1});
        resp_q.push_back('{0, 32'hDEADBEFF, c + 2});
        drive(0, 1'b1, 1'b1, 32'd5, 32'hA5A5A5A5);
        wait_done(0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in the second ACTIVE cycle of a stalled r1 read
        busy_cfg = 5;
        c = cyc;
        cache_q.push_back('{1'b0, 32'd6, 32'd0, 2, c + 1});
        drive(1, 1'b1, 1'b0, 32'd6, 32'd0);
        wait_cycle();
        wait_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_r1_still_stalled", {31'd0, r1_bus.busywait}, 32'd1);
        wait_cycle();
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("abort_cache_read", {31'd0, cache_bus.read}, 32'd0);
        chk("abort_cache_write", {31'd0, cache_bus.write}, 32'd0);
        chk("abort_r1_readdata", r1_bus.readdata, 32'd0);

        // A new request completes normally after the abort
        wait_cycle();
        busy_cfg = 1;
        c = cyc;
        cache_q.push_back('{1'b0, 32'd7, 32'd0, 2, c + 1});
        resp_q.push_back('{0, 32'hDEADBEE9, c + 3});
        drive(0, 1'b1, 1'b0, 32'd7, 32'd0);
        wait_done(0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        busy_cfg = 0;

        repeat (4) wait_cycle();
        chk("cache_queue_drained", cache_q.size(), 32'd0);
        chk("resp_queue_drained", resp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
